// File: rtl/bsg_axil_fifo_master_arbiter_pkg.sv
// Shared types for the AXI-lite fifo-master arbiter: FSM states, request record, pointer helper.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// BSG_AXIL_ARB_REQ_S(aw, dw) expands to the packed request record for a given
// address/data width so every user builds the same field order.
`define BSG_AXIL_ARB_REQ_S(aw, dw) \
  struct packed { \
    logic              w; \
    logic [(aw)-1:0]   addr; \
    logic [(dw)-1:0]   data; \
    logic [(dw)/8-1:0] wmask; \
  }

package bsg_axil_arb_pkg;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_req  = 2'd1,
    e_resp = 2'd2
  } arb_state_e;

  // Next round-robin position after v, wrapping to 0 at n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/bsg_axil_fifo_master_arbiter_if.sv
// Bundles the client-side and downstream-side handshake buses of the arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; "master" is the arbiter's view, "slave" the environment's.
interface bsg_axil_fifo_master_arbiter_if #(
  parameter int num_clients_p = 2,
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 32
);
  localparam int mask_width_lp = data_width_p / 8;

  logic [num_clients_p-1:0]               client_v_i;
  logic [num_clients_p-1:0]               client_w_i;
  logic [num_clients_p*addr_width_p-1:0]  client_addr_i;
  logic [num_clients_p*data_width_p-1:0]  client_data_i;
  logic [num_clients_p*mask_width_lp-1:0] client_wmask_i;
  logic [num_clients_p-1:0]               client_ready_and_o;
  logic [num_clients_p-1:0]               client_v_o;
  logic [data_width_p-1:0]                client_data_o;
  logic                                   client_err_o;
  logic [num_clients_p-1:0]               client_ready_and_i;

  logic                                   m_v_o;
  logic                                   m_w_o;
  logic [addr_width_p-1:0]                m_addr_o;
  logic [data_width_p-1:0]                m_data_o;
  logic [mask_width_lp-1:0]               m_wmask_o;
  logic                                   m_ready_and_i;
  logic                                   m_v_i;
  logic [data_width_p-1:0]                m_data_i;
  logic                                   m_ready_and_o;

  modport master (
    input  client_v_i, client_w_i, client_addr_i, client_data_i, client_wmask_i,
           client_ready_and_i, m_ready_and_i, m_v_i, m_data_i,
    output client_ready_and_o, client_v_o, client_data_o, client_err_o,
           m_v_o, m_w_o, m_addr_o, m_data_o, m_wmask_o, m_ready_and_o
  );

  modport slave (
    output client_v_i, client_w_i, client_addr_i, client_data_i, client_wmask_i,
           client_ready_and_i, m_ready_and_i, m_v_i, m_data_i,
    input  client_ready_and_o, client_v_o, client_data_o, client_err_o,
           m_v_o, m_w_o, m_addr_o, m_data_o, m_wmask_o, m_ready_and_o
  );
endinterface

// File: rtl/bsg_axil_fifo_master_arbiter_rr.sv
// Round-robin grant selector plus the enable/reset register used for request capture.
// Latency: grant is combinational from reqs_i; pointer moves on the yumi_i edge.
// Backpressure: no grant while grants_en_i is low; pointer holds until yumi_i.
//
// bsg_arb_round_robin ports: reqs_i/grants_o (one-hot), tag_o (binary id), v_o, yumi_i.
// bsg_dff_reset_en ports: en_i loads data_i; reset_i clears to zero.
module bsg_arb_round_robin
  import bsg_axil_arb_pkg::*;
#(
  parameter int width_p = 2,
  localparam int tag_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    grants_en_i,
  input  logic [width_p-1:0]      reqs_i,
  output logic [width_p-1:0]      grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o,
  input  logic                    yumi_i
);
  logic [tag_width_lp-1:0] ptr_r;
  logic                    found;
  int                      idx;

  // Scan from the pointer upward with wrap; first requester wins.
  always_comb begin
    found = 1'b0;
    tag_o = '0;
    idx   = 0;
    for (int i = 0; i < width_p; i++) begin
      idx = int'(ptr_r) + i;
      if (idx >= width_p) idx = idx - width_p;
      if (!found && reqs_i[idx]) begin
        found = 1'b1;
        tag_o = idx[tag_width_lp-1:0];
      end
    end
    v_o      = found & grants_en_i;
    grants_o = v_o ? (width_p'(1) << tag_o) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)     ptr_r <= '0;
    else if (yumi_i) ptr_r <= tag_width_lp'(wrap_inc(int'(tag_o), width_p));
  end
endmodule

module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);
  always_ff @(posedge clk_i) begin
    if (reset_i)   data_o <= '0;
    else if (en_i) data_o <= data_i;
  end
endmodule

// File: rtl/bsg_axil_fifo_master_arbiter.sv
// Shares one fifo-master request/response port among num_clients_p clients, one transaction in flight.
// Latency: grant in idle, m_v_o one cycle after accept, response routed combinationally; >=3 cycles/txn.
// Backpressure: m_v_o held until m_ready_and_i; m_ready_and_o follows the owning client's ready.
//
// Ports: clk_i, reset_i (sync, active-high), bus (master modport: client_* and m_* handshakes).
// Optional macro BSG_AXIL_ARB_TIMEOUT_EN: after timeout_cycles_p response-less cycles, return an
// all-ones error beat (client_err_o=1), then drain the next late m_v_i before granting again.
module bsg_axil_fifo_master_arbiter
  import bsg_axil_arb_pkg::*;
#(
  parameter int num_clients_p    = 2,
  parameter int data_width_p     = 32,
  parameter int addr_width_p     = 32,
  parameter int timeout_cycles_p = 1024
) (
  input logic                           clk_i,
  input logic                           reset_i,
  bsg_axil_fifo_master_arbiter_if.master bus
);
  localparam int mask_width_lp = data_width_p / 8;
  localparam int id_width_lp   = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;

  typedef `BSG_AXIL_ARB_REQ_S(addr_width_p, data_width_p) req_s;

  arb_state_e               state_r, state_n;
  logic [num_clients_p-1:0] grants;
  logic [id_width_lp-1:0]   grant_id, id_r;
  logic                     accept, id_ready, timed_out, drain;
  req_s                     req_n, req_r;

  logic [num_clients_p-1:0] client_v_lo;
  logic [data_width_p-1:0]  client_data_lo;
  logic                     client_err_lo, m_ready_lo;

  // Grants are only offered in idle, never while draining, never during reset.
  bsg_arb_round_robin #(.width_p(num_clients_p)) rr (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .grants_en_i ((state_r == e_idle) && !drain && !reset_i),
    .reqs_i      (bus.client_v_i),
    .grants_o    (grants),
    .tag_o       (grant_id),
    .v_o         (accept),
    .yumi_i      (accept)
  );

  assign bus.client_ready_and_o = grants;

  always_comb begin
    req_n.w     = bus.client_w_i[grant_id];
    req_n.addr  = bus.client_addr_i[grant_id*addr_width_p +: addr_width_p];
    req_n.data  = bus.client_data_i[grant_id*data_width_p +: data_width_p];
    req_n.wmask = bus.client_wmask_i[grant_id*mask_width_lp +: mask_width_lp];
  end

  bsg_dff_reset_en #(.width_p($bits(req_s))) req_reg (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(accept), .data_i(req_n), .data_o(req_r)
  );

  bsg_dff_reset_en #(.width_p(id_width_lp)) id_reg (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(accept), .data_i(grant_id), .data_o(id_r)
  );

  assign id_ready = bus.client_ready_and_i[id_r];

`ifdef BSG_AXIL_ARB_TIMEOUT_EN
  localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    drain_r;

  assign timed_out = (state_r == e_resp) && (cnt_r == cnt_width_lp'(timeout_cycles_p));
  assign drain     = drain_r;

  // Counter is zeroed while in e_req so it starts at 0 on the first e_resp cycle; saturates at timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r   <= '0;
      drain_r <= 1'b0;
    end else begin
      if (state_r == e_req)
        cnt_r <= '0;
      else if ((state_r == e_resp) && !bus.m_v_i && !timed_out)
        cnt_r <= cnt_r + 1'b1;
      if (timed_out && id_ready)
        drain_r <= 1'b1;
      else if (drain_r && bus.m_v_i)
        drain_r <= 1'b0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign drain     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n        = state_r;
    client_v_lo    = '0;
    client_data_lo = '0;
    client_err_lo  = 1'b0;
    m_ready_lo     = drain && (state_r == e_idle);
    case (state_r)
      e_idle: if (accept) state_n = e_req;
      e_req:  if (bus.m_ready_and_i) state_n = e_resp;
      e_resp: begin
        if (timed_out) begin
          client_v_lo[id_r] = 1'b1;
          client_data_lo    = '1;
          client_err_lo     = 1'b1;
          if (id_ready) state_n = e_idle;
        end else begin
          client_v_lo[id_r] = bus.m_v_i;
          client_data_lo    = bus.m_data_i;
          m_ready_lo        = id_ready;
          if (bus.m_v_i && id_ready) state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  assign bus.client_v_o    = client_v_lo;
  assign bus.client_data_o = client_data_lo;
  assign bus.client_err_o  = client_err_lo;
  assign bus.m_ready_and_o = m_ready_lo;
  assign bus.m_v_o         = (state_r == e_req);
  assign bus.m_w_o         = req_r.w;
  assign bus.m_addr_o      = req_r.addr;
  assign bus.m_data_o      = req_r.data;
  assign bus.m_wmask_o     = req_r.wmask;
endmodule

// File: tb/tb_bsg_axil_fifo_master_arbiter.sv
// Directed bench for the fifo-master arbiter: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: bench drives m_ready_and_i / client_ready_and_i explicitly per sequence.
module tb_bsg_axil_fifo_master_arbiter;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bsg_axil_fifo_master_arbiter_if #(.num_clients_p(2), .data_width_p(32), .addr_width_p(32)) bus ();

  bsg_axil_fifo_master_arbiter #(
    .num_clients_p(2), .data_width_p(32), .addr_width_p(32), .timeout_cycles_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       v;
    logic [1:0]       w;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] data;
    logic [1:0][3:0]  wmask;
    logic [31:0]      rdata;
    int               g;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [3:0] m0, input logic [3:0] m1,
                              input logic [31:0] rd, input int g);
    vec_t t;
    t.v = v; t.w = w;
    t.addr[0] = a0; t.addr[1] = a1;
    t.data[0] = d0; t.data[1] = d1;
    t.wmask[0] = m0; t.wmask[1] = m1;
    t.rdata = rd; t.g = g;
    return t;
  endfunction

  task automatic drive_clients(input vec_t t);
    bus.client_v_i     = t.v;
    bus.client_w_i     = t.w;
    bus.client_addr_i  = t.addr;
    bus.client_data_i  = t.data;
    bus.client_wmask_i = t.wmask;
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.m_v_o, bus.m_w_o, bus.m_addr_o, bus.m_data_o, bus.m_wmask_o,
            bus.client_v_o, bus.client_ready_and_o, bus.m_ready_and_o, bus.client_err_o,
            bus.client_data_o};
  endfunction

  vec_t t;
  logic [127:0] held;

  initial begin
    bus.client_v_i = '0; bus.client_w_i = '0; bus.client_addr_i = '0;
    bus.client_data_i = '0; bus.client_wmask_i = '0; bus.client_ready_and_i = '0;
    bus.m_ready_and_i = 1'b0; bus.m_v_i = 1'b0; bus.m_data_i = '0;

    // Pointer starts at 0; each row lists the grant the round-robin must pick.
    tbl[0] = mk(2'b01, 2'b01, 32'h30c000, 32'h1000, 32'h1, 32'h55, 4'hf, 4'h3, 32'h0, 0);
    tbl[1] = mk(2'b10, 2'b00, 32'h0, 32'h130800, 32'h0, 32'h0, 4'h0, 4'h0, 32'hdeadbeef, 1);
    tbl[2] = mk(2'b11, 2'b10, 32'h100, 32'h200, 32'ha, 32'hb, 4'h1, 4'h8, 32'h11, 0);
    tbl[3] = mk(2'b11, 2'b10, 32'h100, 32'h200, 32'ha, 32'hb, 4'h1, 4'h8, 32'h22, 1);
    tbl[4] = mk(2'b11, 2'b10, 32'h100, 32'h200, 32'ha, 32'hb, 4'h1, 4'h8, 32'h33, 0);
    tbl[5] = mk(2'b11, 2'b10, 32'h100, 32'h200, 32'ha, 32'hb, 4'h1, 4'h8, 32'h44, 1);
    tbl[6] = mk(2'b10, 2'b10, 32'h0, 32'h400, 32'h0, 32'hc, 4'h0, 4'h6, 32'h55, 1);
    tbl[7] = mk(2'b01, 2'b00, 32'h500, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h66, 0);

    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1 chk("reset_outputs", all_outs(), 128'h0);

    // Table: each transaction is idle(grant) -> req -> resp.
    for (int i = 0; i < 8; i++) begin
      t = tbl[i];
      @(negedge clk);
      bus.m_v_i = 1'b0;
      drive_clients(t);
      bus.client_ready_and_i = 2'b11;
      #1;
      chk("grant_onehot", bus.client_ready_and_o, 2'b01 << t.g);
      chk("idle_no_mv", {bus.m_v_o, bus.m_ready_and_o}, 2'b00);
      @(negedge clk);
      #1;
      chk("req_fields", {bus.m_v_o, bus.m_w_o, bus.m_addr_o, bus.m_data_o, bus.m_wmask_o},
          {1'b1, t.w[t.g], t.addr[t.g], t.data[t.g], t.wmask[t.g]});
      chk("req_no_ready", {bus.client_ready_and_o, bus.m_ready_and_o, bus.client_v_o}, 5'b0);
      bus.m_ready_and_i = 1'b1;
      @(negedge clk);
      bus.m_ready_and_i = 1'b0;
      bus.client_v_i = 2'b00;
      bus.m_v_i = 1'b1;
      bus.m_data_i = t.rdata;
      #1;
      chk("resp_route", {bus.client_v_o, bus.client_data_o}, {2'b01 << t.g, t.rdata});
      chk("resp_ready_err", {bus.m_ready_and_o, bus.client_err_o, bus.m_v_o}, 3'b100);
    end
    @(negedge clk);
    bus.m_v_i = 1'b0;

    // Downstream stall: request held stable for 10 cycles, client0 kept waiting (pointer is 1).
    t = mk(2'b11, 2'b10, 32'h40, 32'habc0, 32'h9, 32'h1234, 4'h2, 4'hf, 32'h0, 1);
    drive_clients(t);
    #1 chk("stall_grant", bus.client_ready_and_o, 2'b10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("stall_hold", {bus.m_v_o, bus.m_w_o, bus.m_addr_o, bus.m_data_o, bus.m_wmask_o,
                         bus.client_ready_and_o},
          {1'b1, 1'b1, 32'habc0, 32'h1234, 4'hf, 2'b00});
    end
    bus.m_ready_and_i = 1'b1;
    @(negedge clk);
    bus.m_ready_and_i = 1'b0;
    bus.client_v_i = 2'b00;
    bus.m_v_i = 1'b1;
    bus.m_data_i = 32'h0;
    #1 chk("stall_resp", bus.client_v_o, 2'b10);
    @(negedge clk);
    bus.m_v_i = 1'b0;

    // Response stall: client1 read, client1 not ready for 5 cycles while client0 waits.
    t = mk(2'b10, 2'b00, 32'h0, 32'h130800, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 1);
    drive_clients(t);
    #1 chk("rstall_grant", bus.client_ready_and_o, 2'b10);
    @(negedge clk);
    bus.client_v_i = 2'b11;
    bus.m_ready_and_i = 1'b1;
    #1 chk("rstall_req", {bus.m_v_o, bus.m_addr_o}, {1'b1, 32'h130800});
    @(negedge clk);
    bus.m_ready_and_i = 1'b0;
    bus.m_v_i = 1'b1;
    bus.m_data_i = 32'h130800;
    bus.client_ready_and_i = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rstall_hold", {bus.m_ready_and_o, bus.client_ready_and_o, bus.client_v_o, bus.client_data_o},
          {1'b0, 2'b00, 2'b10, 32'h130800});
      @(negedge clk);
    end
    bus.client_ready_and_i = 2'b11;
    #1 chk("rstall_release", {bus.m_ready_and_o, bus.client_v_o, bus.client_data_o},
           {1'b1, 2'b10, 32'h130800});
    @(negedge clk);
    bus.m_v_i = 1'b0;
    t = mk(2'b11, 2'b01, 32'h77, 32'h88, 32'h5, 32'h6, 4'h1, 4'h1, 32'h0, 0);
    drive_clients(t);
    #1 chk("rstall_next_grant", bus.client_ready_and_o, 2'b01);

    // Reset while in e_req (client0 granted, so pointer had moved to 1).
    @(negedge clk);
    #1 chk("rst_in_req", {bus.m_v_o, bus.m_addr_o}, {1'b1, 32'h77});
    reset_i = 1'b1;
    bus.client_v_i = 2'b00;
    @(negedge clk);
    reset_i = 1'b0;
    #1 chk("rst_outputs", all_outs(), 128'h0);
    @(negedge clk);
    t = mk(2'b11, 2'b11, 32'hc0, 32'hd0, 32'h12, 32'h34, 4'h3, 4'hc, 32'hbeef, 0);
    drive_clients(t);
    #1 chk("rst_ptr_zero", bus.client_ready_and_o, 2'b01);
    @(negedge clk);
    bus.m_ready_and_i = 1'b1;
    #1 chk("rst_req", {bus.m_v_o, bus.m_addr_o, bus.m_data_o, bus.m_wmask_o},
           {1'b1, 32'hc0, 32'h12, 4'h3});
    @(negedge clk);
    bus.m_ready_and_i = 1'b0;
    bus.client_v_i = 2'b00;
    bus.m_v_i = 1'b1;
    bus.m_data_i = 32'hbeef;
    #1 chk("rst_resp", {bus.client_v_o, bus.client_data_o}, {2'b01, 32'hbeef});
    @(negedge clk);
    bus.m_v_i = 1'b0;

`ifdef BSG_AXIL_ARB_TIMEOUT_EN
    // Timeout: no response for 8 e_resp cycles, then error beat, then drain of late m_v_i.
    t = mk(2'b01, 2'b00, 32'he0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
    drive_clients(t);
    #1 chk("to_grant", bus.client_ready_and_o, 2'b01);
    @(negedge clk);
    bus.m_ready_and_i = 1'b1;
    @(negedge clk);
    bus.m_ready_and_i = 1'b0;
    bus.client_v_i = 2'b10;
    for (int c = 0; c < 8; c++) begin
      #1 chk("to_wait", {bus.client_v_o, bus.client_ready_and_o, bus.client_err_o}, 5'b0);
      @(negedge clk);
    end
    #1 chk("to_error", {bus.client_v_o, bus.client_data_o, bus.client_err_o, bus.m_ready_and_o},
           {2'b01, 32'hffffffff, 1'b1, 1'b0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("to_drain_block", {bus.client_ready_and_o, bus.m_ready_and_o, bus.client_err_o},
             {2'b00, 1'b1, 1'b0});
    end
    @(negedge clk);
    bus.m_v_i = 1'b1;
    bus.m_data_i = 32'h77;
    #1 chk("to_discard", {bus.client_v_o, bus.client_ready_and_o, bus.m_ready_and_o},
           {2'b00, 2'b00, 1'b1});
    @(negedge clk);
    bus.m_v_i = 1'b0;
    #1 chk("to_regrant", {bus.client_ready_and_o, bus.m_ready_and_o}, {2'b10, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
